// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use/multi-cycle stall generation for the EX stage.
// Tracks in-flight destination tags over DEPTH post-EX stages and counts stall cycles.
module fwd_hazard_unit #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned SW      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_kill,
   input  logic                  ex_regwrite,
   input  logic [AW-1:0]         ex_rd,
   input  logic [SW-1:0]         ex_rdy_stage,
   input  logic [NUM_SRC*AW-1:0] ex_rs,
   input  logic [NUM_SRC-1:0]    ex_rs_used,
   input  logic                  stat_clr,
   output logic [NUM_SRC*SW-1:0] fwd_sel,
   output logic                  stall,
   output logic [15:0]           stall_cnt
);

   localparam int unsigned CW      = 16;
   localparam logic [CW-1:0] CNT_MAX = 16'hFFFF;
   localparam logic [SW-1:0] RDY_MIN = SW'(1);
   localparam logic [SW-1:0] RDY_MAX = SW'(DEPTH);

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rd;
      logic [SW-1:0] rdy;
   } entry_t;

   entry_t                r_trk [1:DEPTH];
   logic [CW-1:0]         r_stall_cnt;

   entry_t                w_new;
   logic [SW-1:0]         w_rdy_clamp;
   logic [NUM_SRC-1:0]    w_pend;
   logic [NUM_SRC*SW-1:0] w_fwd_sel;
   logic                  w_stall;

   // Ready stage is forced into 1..DEPTH so every tag eventually becomes forwardable.
   always_comb begin
      w_rdy_clamp = ex_rdy_stage;
      if (ex_rdy_stage == '0) begin
         w_rdy_clamp = RDY_MIN;
      end else if (ex_rdy_stage > RDY_MAX) begin
         w_rdy_clamp = RDY_MAX;
      end
   end

   // Scan oldest to youngest so the youngest matching stage has the final say.
   always_comb begin
      w_fwd_sel = '0;
      w_pend    = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (r_trk[k].v && ex_rs_used[i] && (ex_rs[i*AW +: AW] != '0) &&
                (r_trk[k].rd == ex_rs[i*AW +: AW])) begin
               if (SW'(k) >= r_trk[k].rdy) begin
                  w_fwd_sel[i*SW +: SW] = SW'(k);
                  w_pend[i]             = 1'b0;
               end else begin
                  w_fwd_sel[i*SW +: SW] = '0;
                  w_pend[i]             = 1'b1;
               end
            end
         end
      end
   end

   assign w_stall = ex_valid & ~ex_kill & (|w_pend);

   // A stalled or killed instruction enters stage 1 as a bubble.
   always_comb begin
      w_new     = '0;
      w_new.v   = ex_valid & ex_regwrite & (ex_rd != '0) & ~ex_kill & ~w_stall;
      w_new.rd  = ex_rd;
      w_new.rdy = w_rdy_clamp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 1; k <= DEPTH; k++) begin
            r_trk[k] <= '0;
         end
      end else begin
         r_trk[1] <= w_new;
         for (int unsigned k = 2; k <= DEPTH; k++) begin
            r_trk[k] <= r_trk[k-1];
         end
      end
   end

   // Saturating stall-cycle counter; a clear in the same cycle as a stall wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stat_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CW'(1);
      end
   end

   assign fwd_sel   = w_fwd_sel;
   assign stall     = w_stall;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a DEPTH=2 and a DEPTH=4 instance share
// the EX-stage stimulus; expected select/stall/count values are queued per cycle.
module tb_fwd_hazard_unit;

   localparam int unsigned AW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid, ex_kill, ex_regwrite, stat_clr;
   logic [AW-1:0]   ex_rd;
   logic [1:0]      rdy_a;
   logic [2:0]      rdy_b;
   logic [2*AW-1:0] ex_rs;
   logic [1:0]      ex_rs_used;
   logic [3:0]      sel_a;
   logic [5:0]      sel_b;
   logic            stall_a, stall_b;
   logic [15:0]     cnt_a, cnt_b;

   typedef struct {
      string       tag;
      logic [3:0]  sel_a;
      logic        st_a;
      logic [15:0] cnt_a;
      logic [5:0]  sel_b;
      logic        st_b;
      logic [15:0] cnt_b;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        m_e;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt_a = 16'h0;
   logic [15:0] exp_cnt_b = 16'h0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.DEPTH(2), .NUM_SRC(2), .AW(AW)) u_a (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_kill(ex_kill),
      .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_rdy_stage(rdy_a),
      .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .stat_clr(stat_clr),
      .fwd_sel(sel_a), .stall(stall_a), .stall_cnt(cnt_a)
   );

   fwd_hazard_unit #(.DEPTH(4), .NUM_SRC(2), .AW(AW)) u_b (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_kill(ex_kill),
      .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_rdy_stage(rdy_b),
      .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .stat_clr(stat_clr),
      .fwd_sel(sel_b), .stall(stall_b), .stall_cnt(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one EX cycle and queue what both instances must show during it.
   task automatic step(input string tag, input logic v, input logic kl, input logic rw,
                       input logic [4:0] rd, input logic [2:0] rdy,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic clr,
                       input logic [1:0] a0, input logic [1:0] a1, input logic sa,
                       input logic [2:0] b0, input logic [2:0] b1, input logic sb);
      exp_t e;
      @(posedge clk);
      #1;
      ex_valid    = v;
      ex_kill     = kl;
      ex_regwrite = rw;
      ex_rd       = rd;
      rdy_a       = (rdy > 3'd3) ? 2'd3 : rdy[1:0];
      rdy_b       = rdy;
      ex_rs       = {rs1, rs0};
      ex_rs_used  = used;
      stat_clr    = clr;
      e.tag   = tag;
      e.sel_a = {a1, a0};
      e.st_a  = sa;
      e.cnt_a = exp_cnt_a;
      e.sel_b = {b1, b0};
      e.st_b  = sb;
      e.cnt_b = exp_cnt_b;
      sb_q.push_back(e);
      exp_cnt_a = clr ? 16'h0 : ((sa && exp_cnt_a != 16'hFFFF) ? exp_cnt_a + 16'h1 : exp_cnt_a);
      exp_cnt_b = clr ? 16'h0 : ((sb && exp_cnt_b != 16'hFFFF) ? exp_cnt_b + 16'h1 : exp_cnt_b);
   endtask

   task automatic idle();
      step("idle", 0,0,0, 0,0, 0,0,2'b00,0, 0,0,0, 0,0,0);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         m_e = sb_q.pop_front();
         chk({m_e.tag, "/sel_a"},   32'(sel_a),   32'(m_e.sel_a));
         chk({m_e.tag, "/stall_a"}, 32'(stall_a), 32'(m_e.st_a));
         chk({m_e.tag, "/cnt_a"},   32'(cnt_a),   32'(m_e.cnt_a));
         chk({m_e.tag, "/sel_b"},   32'(sel_b),   32'(m_e.sel_b));
         chk({m_e.tag, "/stall_b"}, 32'(stall_b), 32'(m_e.st_b));
         chk({m_e.tag, "/cnt_b"},   32'(cnt_b),   32'(m_e.cnt_b));
      end
   end

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_kill = 1'b0; ex_regwrite = 1'b0;
      ex_rd = '0; rdy_a = '0; rdy_b = '0; ex_rs = '0; ex_rs_used = '0; stat_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset/stall_a", 32'(stall_a), 32'd0);
      chk("reset/cnt_a",   32'(cnt_a),   32'd0);
      chk("reset/sel_b",   32'(sel_b),   32'd0);
      chk("reset/cnt_b",   32'(cnt_b),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //   tag            v k w rd rdy rs0 rs1 used  clr  a0 a1 sa  b0 b1 sb
      step("alu_prod",    1,0,1, 5,1,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("alu_b2b",     1,0,0, 0,0,  5, 0, 2'b01,0,   1,0,0,   1,0,0);
      step("alu_gap",     1,0,0, 0,0,  5, 0, 2'b01,0,   2,0,0,   2,0,0);
      step("alu_retire",  1,0,0, 0,0,  5, 0, 2'b01,0,   0,0,0,   3,0,0);
      idle();
      step("dbl_w1",      1,0,1, 7,1,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("dbl_w2",      1,0,1, 7,1,  7, 0, 2'b01,0,   1,0,0,   1,0,0);
      step("dbl_rd",      1,0,0, 0,0,  0, 7, 2'b10,0,   0,1,0,   0,1,0);
      step("dbl_rd2",     1,0,0, 0,0,  0, 7, 2'b10,0,   0,2,0,   0,2,0);
      idle(); idle();
      step("ld_prod",     1,0,1, 3,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("ld_stall",    1,0,1, 9,1,  3, 0, 2'b01,0,   0,0,1,   0,0,1);
      step("ld_fwd",      1,0,1, 9,1,  3, 9, 2'b11,0,   2,0,0,   2,0,0);
      step("ld_nodup",    1,0,0, 0,0,  9, 3, 2'b11,0,   1,0,0,   1,3,0);
      idle(); idle(); idle();
      step("x0_w",        1,0,1, 0,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("x0_r",        1,0,1, 0,2,  0, 0, 2'b11,0,   0,0,0,   0,0,0);
      step("unused_w",    1,0,1, 4,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("unused_r",    1,0,0, 0,0,  4, 4, 2'b00,0,   0,0,0,   0,0,0);
      step("unused_chk",  1,0,0, 0,0,  4, 0, 2'b01,0,   2,0,0,   2,0,0);
      idle(); idle();
      step("kill_prod",   1,0,1, 6,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("kill_use",    1,1,1, 8,1,  6, 0, 2'b01,0,   0,0,0,   0,0,0);
      step("kill_chk",    1,0,0, 0,0,  8, 6, 2'b11,0,   0,2,0,   0,2,0);
      idle(); idle();
      step("lng_prod",    1,0,1,10,4,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("lng_s1",      1,0,0, 0,0, 10, 0, 2'b01,0,   0,0,1,   0,0,1);
      step("lng_s2",      1,0,0, 0,0, 10, 0, 2'b01,0,   2,0,0,   0,0,1);
      step("lng_s3",      1,0,0, 0,0, 10, 0, 2'b01,0,   0,0,0,   0,0,1);
      step("lng_fwd",     1,0,0, 0,0, 10, 0, 2'b01,0,   0,0,0,   4,0,0);
      step("clr_prod",    1,0,1,11,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("clr_stall",   1,0,0, 0,0, 11, 0, 2'b01,1,   0,0,1,   0,0,1);
      step("clr_after",   1,0,0, 0,0, 11, 0, 2'b01,0,   2,0,0,   2,0,0);

      @(negedge clk);
      #1;
      force u_a.r_stall_cnt = 16'hFFFF;
      #1;
      release u_a.r_stall_cnt;
      exp_cnt_a = 16'hFFFF;
      step("sat_prod",    1,0,1,12,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("sat_stall",   1,0,0, 0,0, 12, 0, 2'b01,0,   0,0,1,   0,0,1);
      step("sat_hold",    1,0,0, 0,0, 12, 0, 2'b01,0,   2,0,0,   2,0,0);

      step("rst_prod",    1,0,1,13,2,  0, 0, 2'b00,0,   0,0,0,   0,0,0);
      step("rst_stall",   1,0,0, 0,0, 13, 0, 2'b01,0,   0,0,1,   0,0,1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid/stall_a", 32'(stall_a), 32'd0);
      chk("rst_mid/stall_b", 32'(stall_b), 32'd0);
      chk("rst_mid/cnt_a",   32'(cnt_a),   32'd0);
      chk("rst_mid/cnt_b",   32'(cnt_b),   32'd0);
      exp_cnt_a = 16'h0;
      exp_cnt_b = 16'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_after",   1,0,0, 0,0, 13, 0, 2'b01,0,   0,0,0,   0,0,0);

      repeat (2) @(negedge clk);
      #1;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined core, generalising two-stage EX/MEM–MEM/WB forwarding to an arbitrary number of post-EX stages, source operands, and per-instruction result latency. The unit keeps its own shift register of in-flight destination tags and, for each EX-stage source operand, selects the youngest producing stage or the register file. It raises a stall when the youngest matching producer has not yet produced its result (load-use and multi-cycle cases), and counts stall cycles for performance monitoring.

## Interface
- `DEPTH`, default 2: tracked post-EX stages. Stage 1 is EX/MEM, stage 2 is MEM/WB, and so on. Legal range is ≥1.
- `NUM_SRC`, default 2: source operands checked per EX instruction.
- `AW`, default 5: register address width.
- `SW`, default $clog2(DEPTH+1): width of one forward-select field.
- `clk` input, 1 bit: clock. The unit uses a single clock domain and updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ex_valid` input, 1 bit: the ID/EX register holds a real instruction.
- `ex_kill` input, 1 bit: the EX instruction is flushed (branch redirect). It must not enter stage 1.
- `ex_regwrite` input, 1 bit: the EX instruction writes `ex_rd`.
- `ex_rd` input, AW bits: destination register of the EX instruction.
- `ex_rdy_stage` input, SW bits: first stage whose output carries the result. ALU = 1, load = 2.
- `ex_rs` input, NUM_SRC*AW bits: source registers, flattened. Operand i occupies bits [i*AW +: AW].
- `ex_rs_used` input, NUM_SRC bits: operand i is actually read.
- `stat_clr` input, 1 bit: synchronously clears the stall counter.
- `fwd_sel` output, NUM_SRC*SW bits: per operand, 0 selects the register file and k (1..DEPTH) selects the stage-k result.
- `stall` output, 1 bit: hold the IF/ID and ID/EX registers, and insert a bubble into stage 1.
- `stall_cnt` output, 16 bits: saturating count of stall cycles.

## Operation
- Tracker:
  - Each entry k (1..DEPTH) holds `v`, `rd`, `rdy`.
  - Each cycle, entry k moves to entry k+1 unconditionally. Entry DEPTH retires to the register file.
  - The register file is write-through, so a consumer entering EX in the following cycle reads the retired value.
- Entry 1 load:
  - Loaded with `v = ex_valid & ex_regwrite & (ex_rd != 0) & !ex_kill & !stall`, together with `rd = ex_rd` and `rdy = clamp(ex_rdy_stage)`.
  - The clamp maps 0 to 1 and values above DEPTH to DEPTH.
  - Otherwise entry 1 is loaded as a bubble (`v = 0`).
- Match for operand i, stage k: `v_k & ex_rs_used[i] & (rs_i != 0) & (rd_k == rs_i)`.
- Youngest match wins: the smallest matching k.
  - If k ≥ `rdy_k`, then `fwd_sel[i] = k`.
  - If k < `rdy_k`, then `fwd_sel[i] = 0` and the operand is pending.
  - If nothing matches, `fwd_sel[i] = 0`.
- An older match is never used when a younger match exists, even if the younger one is pending.
- `stall = ex_valid & !ex_kill & (any operand pending)`.
- `ex_kill` overrides `stall`: killed instructions never stall.
- During a stall, the tracker keeps advancing. The pending producer therefore reaches its ready stage, and `stall` drops automatically.
- Stall counter:
  - Increments each cycle `stall` = 1 and saturates at 16'hFFFF.
  - If `stat_clr` and `stall` are asserted together, the result is 0: clear wins.

## Timing
- `fwd_sel` and `stall` are combinational from registered tracker state and the current `ex_*` inputs. There is no additional latency.
- Tracker state and `stall_cnt` update on the rising edge of `clk`.
- Reset (`rst_n` = 0, asynchronous):
  - All entry `v` bits clear to 0.
  - `stall_cnt` clears to 0.
  - As a result, `fwd_sel` = 0 and `stall` = 0 while reset is held.
  - Reset mid-stall discards all in-flight tags. The first cycle after release starts from an empty pipe.
- Worst-case stall length for one producer is `rdy - 1` cycles.
- A second dependent operand on a different producer may extend the stall; each cycle is evaluated independently.
- `ex_rd` = 0 never allocates an entry. `rs` = 0 never forwards and never stalls.

## Test plan
- **ALU back-to-back:** with DEPTH=2, x5 is produced with rdy=1, then the next EX reads rs1=x5 → `fwd_sel[0]` = 1, `stall` = 0. One cycle later with a bubble in between, it reads x5 → `fwd_sel[0]` = 2.
- **Double hazard:** two consecutive writes to x7 (rdy=1), then a read of x7 on rs2 → `fwd_sel[1]` = 1 (youngest), not 2.
- **Load-use:** a load to x3 (rdy=2), then a reader of x3 →
  - `stall` = 1 for exactly one cycle, and `stall_cnt` increments to 1.
  - The next cycle gives `fwd_sel[0]` = 2 with `stall` = 0.
  - No duplicate entry is created for the held instruction.
- **Zero register and unused operand:**
  - A write to x0 followed by a read of x0 → `fwd_sel` = 0, `stall` = 0.
  - A matching rs with `ex_rs_used` = 0 → `fwd_sel` = 0.
- **Kill and reset:**
  - A pending load hazard with `ex_kill` = 1 → `stall` = 0, and the killed instruction does not appear in stage 1.
  - Asserting `rst_n` = 0 mid-stall → `stall` = 0 immediately and `stall_cnt` = 0.
- **Counter saturation and clear:**
  - Force `stall_cnt` to 16'hFFFF, then hold a stall → it stays at FFFF.
  - `stat_clr` together with `stall` → 0.
  - Repeat the load-use test with DEPTH=4, rdy=4 → a 3-cycle stall, then `fwd_sel` = 4.
